// File: rtl/fir_sum_tree.sv
// Pipelined adder tree for the parallel FIR: sums NTAP unsigned products with one register
// level per tree level, then rounds half up, shifts right and saturates into the output word.
module fir_sum_tree #(
    parameter int unsigned NTAP  = 8,
    parameter int unsigned PW    = 8,
    parameter int unsigned SHIFT = 3,
    parameter int unsigned OW    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NTAP*PW-1:0] prod,
    output logic [OW-1:0]      result,
    output logic               rdy,
    output logic               sat
);

    localparam int unsigned L  = $clog2(NTAP);
    localparam int unsigned SW = PW + L;

    function automatic int unsigned nodes_at(input int unsigned k);
        int unsigned n;
        n = NTAP;
        for (int unsigned i = 0; i < k; i++) n = (n + 1) / 2;
        return n;
    endfunction

    // All tree levels live in one flat array; level k starts at offset_at(k).
    function automatic int unsigned offset_at(input int unsigned k);
        int unsigned o;
        o = 0;
        for (int unsigned i = 0; i < k; i++) o += nodes_at(i);
        return o;
    endfunction

    function automatic logic [SW:0] round_const();
        logic [SW:0] r;
        r = '0;
        if (SHIFT > 0) r[SHIFT-1] = 1'b1;
        return r;
    endfunction

    localparam int unsigned T   = offset_at(L + 1);
    localparam logic [SW:0] RND = round_const();

    logic [SW-1:0] node_q [T];
    logic [L+1:1]  vld_q;
    logic [L+1:0]  vld;

    assign vld = {vld_q, en};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld[L:0];
        end
    end

    for (genvar i = 0; i < NTAP; i++) begin : g_in
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                node_q[i] <= '0;
            end else if (en) begin
                node_q[i] <= SW'(prod[i*PW +: PW]);
            end
        end
    end

    for (genvar k = 1; k <= L; k++) begin : g_lvl
        localparam int unsigned NK = nodes_at(k);
        localparam int unsigned NP = nodes_at(k - 1);
        localparam int unsigned OK = offset_at(k);
        localparam int unsigned OP = offset_at(k - 1);
        for (genvar j = 0; j < NK; j++) begin : g_node
            if (2 * j + 1 < NP) begin : g_add
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        node_q[OK+j] <= '0;
                    end else if (vld[k]) begin
                        node_q[OK+j] <= node_q[OP+2*j] + node_q[OP+2*j+1];
                    end
                end
            end else begin : g_pass
                // Odd leftover node is re-registered so every path has the same depth.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        node_q[OK+j] <= '0;
                    end else if (vld[k]) begin
                        node_q[OK+j] <= node_q[OP+2*j];
                    end
                end
            end
        end
    end

    logic [SW:0]   rounded;
    logic [SW:0]   shifted;
    logic [OW-1:0] res_c;
    logic          sat_c;

    assign rounded = {1'b0, node_q[T-1]} + RND;
    assign shifted = rounded >> SHIFT;

    if (SW + 1 > OW) begin : g_clip
        assign sat_c = |shifted[SW:OW];
        assign res_c = sat_c ? {OW{1'b1}} : shifted[OW-1:0];
    end else begin : g_noclip
        assign sat_c = 1'b0;
        assign res_c = OW'(shifted);
    end

    logic [OW-1:0] result_q;
    logic          rdy_q;
    logic          sat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            rdy_q    <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            rdy_q <= vld[L+1];
            if (vld[L+1]) begin
                result_q <= res_c;
                sat_q    <= sat_c;
            end
        end
    end

    assign result = result_q;
    assign rdy    = rdy_q;
    assign sat    = sat_q;

endmodule

// File: tb/tb_fir_sum_tree.sv
// Scoreboard bench for fir_sum_tree: three instances (defaults, SHIFT=2, NTAP=5/SHIFT=0)
// driven with directed vectors; a negedge monitor pops expected results when rdy fires.
module tb_fir_sum_tree;

    typedef struct {
        logic [7:0] res;
        logic       sat;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [63:0] prod8 = '0;
    logic [39:0] prod5 = '0;
    logic [7:0]  result_a, result_b, result_c;
    logic        rdy_a, rdy_b, rdy_c;
    logic        sat_a, sat_b, sat_c;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_sum_tree u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .prod(prod8),
        .result(result_a), .rdy(rdy_a), .sat(sat_a)
    );

    fir_sum_tree #(.NTAP(8), .PW(8), .SHIFT(2), .OW(8)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .prod(prod8),
        .result(result_b), .rdy(rdy_b), .sat(sat_b)
    );

    fir_sum_tree #(.NTAP(5), .PW(8), .SHIFT(0), .OW(8)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en), .prod(prod5),
        .result(result_c), .rdy(rdy_c), .sat(sat_c)
    );

    task automatic cmp(input string name, input logic [7:0] res, input logic s, input exp_t e);
        n_cmp++;
        if (res !== e.res || s !== e.sat || cyc !== e.cyc) begin
            n_err++;
            $display("FAIL %s: got result=%0d sat=%0b cycle=%0d, want result=%0d sat=%0b cycle=%0d",
                     name, res, s, cyc, e.res, e.sat, e.cyc);
        end
    endtask

    task automatic spurious(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s_unexpected_rdy: got rdy=1 at cycle %0d, want rdy=0", name, cyc);
    endtask

    always @(negedge clk) begin
        if (rdy_a) begin
            if (qa.size() == 0) spurious("a");
            else cmp("a_result", result_a, sat_a, qa.pop_front());
        end
        if (rdy_b) begin
            if (qb.size() == 0) spurious("b");
            else cmp("b_result", result_b, sat_b, qb.pop_front());
        end
        if (rdy_c) begin
            if (qc.size() == 0) spurious("c");
            else cmp("c_result", result_c, sat_c, qc.pop_front());
        end
    end

    // Called at a negedge: presents one sample for the next rising edge and records
    // what each instance must produce five cycles later.
    task automatic issue(input logic [63:0] pa, input logic [7:0] ea, input logic sa,
                         input logic [7:0] eb, input logic sb,
                         input logic [39:0] pc, input logic [7:0] ec, input logic sc);
        en    = 1'b1;
        prod8 = pa;
        prod5 = pc;
        qa.push_back('{res: ea, sat: sa, cyc: cyc + 5});
        qb.push_back('{res: eb, sat: sb, cyc: cyc + 5});
        qc.push_back('{res: ec, sat: sc, cyc: cyc + 5});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        en = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_quiet(input string name, input logic [7:0] want_res);
        n_cmp++;
        if (rdy_a || rdy_b || rdy_c || result_a !== want_res || sat_a) begin
            n_err++;
            $display("FAIL %s: got rdy=%0b%0b%0b result_a=%0d sat_a=%0b, want rdy=000 result_a=%0d sat_a=0",
                     name, rdy_a, rdy_b, rdy_c, result_a, sat_a, want_res);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (qa.size() + qb.size() + qc.size()) != 0; i++) @(negedge clk);
        if ((qa.size() + qb.size() + qc.size()) != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d/%0d/%0d pending, want 0/0/0",
                     qa.size(), qb.size(), qc.size());
            qa.delete();
            qb.delete();
            qc.delete();
        end
    endtask

    initial begin
        // Reset held with activity on the inputs.
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            prod8 = {$urandom, $urandom};
            prod5 = {8'($urandom), $urandom};
            @(negedge clk);
            check_quiet("reset_outputs", 8'd0);
        end
        rst_n = 1'b1;
        en    = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_quiet("post_reset_idle", 8'd0);
        end

        // Single pulses, one at a time.
        issue(64'h0101010101010101, 8'd1, 1'b0, 8'd2, 1'b0, 40'h0101010101, 8'd5, 1'b0);
        idle(6);
        issue(64'h0807060504030201, 8'd5, 1'b0, 8'd9, 1'b0, 40'h0504030201, 8'd15, 1'b0);
        idle(6);
        issue(64'h0000000000000004, 8'd1, 1'b0, 8'd1, 1'b0, 40'h32281E140A, 8'd150, 1'b0);
        idle(6);
        issue(64'h0000000000000003, 8'd0, 1'b0, 8'd1, 1'b0, 40'h0000000000, 8'd0, 1'b0);
        idle(6);
        issue(64'hFFFFFFFFFFFFFFFF, 8'd255, 1'b0, 8'd255, 1'b1, 40'hFFFFFFFFFF, 8'd255, 1'b1);
        idle(6);
        drain();

        // Back-to-back: sums 8, 36, 3.
        issue(64'h0101010101010101, 8'd1, 1'b0, 8'd2, 1'b0, 40'h32281E140A, 8'd150, 1'b0);
        issue(64'h0807060504030201, 8'd5, 1'b0, 8'd9, 1'b0, 40'hFFFFFFFFFF, 8'd255, 1'b1);
        issue(64'h0000000000000003, 8'd0, 1'b0, 8'd1, 1'b0, 40'h0504030201, 8'd15, 1'b0);
        idle(1);
        drain();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_quiet("hold_after_rdy", 8'd0);
        end

        // Reset two cycles after a pulse: that sample must never emerge.
        en    = 1'b1;
        prod8 = 64'h0101010101010101;
        prod5 = 40'h0101010101;
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_quiet("midflight_reset", 8'd0);
        rst_n = 1'b1;
        // Accepted in the same cycle reset is released.
        issue(64'h0807060504030201, 8'd5, 1'b0, 8'd9, 1'b0, 40'h32281E140A, 8'd150, 1'b0);
        idle(8);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, want finish before 100000");
        $fatal(1);
    end

endmodule
